// File: rtl/mem_responder.sv
// mem_responder -- memory-side responder for the multicycle controller.
//
// Services memread/memwrite requests against an internal single-port RAM
// (synchronous read, registered output) and, when built with MEM_IO_EN,
// a small memory-mapped I/O window. Completion is a one-cycle ready pulse.
//
// Optional feature macro: MEM_IO_EN (I/O window at IO_BASE; io_out register
// at IO_BASE+1, io_in readable at IO_BASE). Without it io_out is tied low.
//
// Handshake: requests are levels sampled only while IDLE. Each accepted
// request produces exactly one ready pulse (err coincident when the access
// was illegal); levels seen in RD_WAIT/ACK are ignored, so the controller
// must drop its request in the cycle it sees ready.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   memread, memwrite request levels
//   addr, wdata       word address, write data
//   rdata             registered read data (held until the next read)
//   ready, busy, err  completion pulse, not-idle flag, error pulse
//   io_in, io_out     switch inputs, LED/display register
//   fsm_state         current FSM state for observation
module mem_responder #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter logic [15:0] IO_BASE   = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err,
  input  logic [15:0] io_in,
  output logic [15:0] io_out,
  output logic [1:0]  fsm_state
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, ACK = 2'd2} state_t;
  // Where the pending read's data comes from, chosen when the read is accepted.
  typedef enum logic [1:0] {SRC_RAM, SRC_IO_IN, SRC_IO_OUT, SRC_ZERO} src_t;

  state_t      state;
  src_t        src;
  logic        err_q;
  logic [15:0] mem [MEM_DEPTH];
  logic [15:0] ram_q;
  logic [AW-1:0] idx;
  logic        in_range;
  logic        in_ram;
  logic        is_io_in;
  logic        is_io_out;
  logic        rd_req;
  logic        wr_req;

  assign idx      = addr[AW-1:0];
  assign in_range = ({16'd0, addr} < MEM_DEPTH);

`ifdef MEM_IO_EN
  logic        in_window;
  logic [15:0] io_out_q;

  // The whole 256-word window is carved out of the RAM space; only the two
  // decoded words are live, the rest behave as out-of-range.
  assign in_window = ({1'b0, addr} >= {1'b0, IO_BASE}) &&
                     ({1'b0, addr} <  ({1'b0, IO_BASE} + 17'd256));
  assign is_io_in  = (addr == IO_BASE);
  assign is_io_out = (addr == IO_BASE + 16'd1);
  assign in_ram    = in_range && !in_window;
  assign io_out    = io_out_q;
`else
  logic unused_io;

  assign unused_io = ^io_in;
  assign is_io_in  = 1'b0;
  assign is_io_out = 1'b0;
  assign in_ram    = in_range;
  assign io_out    = 16'h0000;
`endif

  assign rd_req = (state == IDLE) && memread && !memwrite;
  assign wr_req = (state == IDLE) && memwrite && !memread;

  // RAM array: no reset on contents. The read register captures the word at
  // the accept edge; the FSM copies it into rdata one edge later.
  always_ff @(posedge clk) begin
    if (wr_req && in_ram && !reset) mem[idx] <= wdata;
    if (rd_req) ram_q <= mem[idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      src   <= SRC_ZERO;
      err_q <= 1'b0;
      rdata <= 16'h0000;
`ifdef MEM_IO_EN
      io_out_q <= 16'h0000;
`endif
    end else begin
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (memread && memwrite) begin
            err_q <= 1'b1;
            state <= ACK;
          end else if (memwrite) begin
            // Writes to RAM commit in the RAM block; only io_out lives here.
`ifdef MEM_IO_EN
            if (is_io_out) io_out_q <= wdata;
`endif
            err_q <= !(in_ram || is_io_out);
            state <= ACK;
          end else if (memread) begin
            if (in_ram)         src <= SRC_RAM;
            else if (is_io_in)  src <= SRC_IO_IN;
            else if (is_io_out) src <= SRC_IO_OUT;
            else                src <= SRC_ZERO;
            err_q <= !(in_ram || is_io_in || is_io_out);
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          case (src)
            SRC_RAM:    rdata <= ram_q;
`ifdef MEM_IO_EN
            SRC_IO_IN:  rdata <= io_in;
            SRC_IO_OUT: rdata <= io_out_q;
`endif
            default:    rdata <= 16'h0000;
          endcase
          state <= ACK;
        end
        ACK: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready     = (state == ACK);
  assign busy      = (state != IDLE);
  assign err       = (state == ACK) && err_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder -- directed plus randomized bench for mem_responder.
// The reference model is a word-addressed associative memory plus the
// address-class rules; expected read data goes through exp_q.
module tb_mem_responder;

  localparam int          DEPTH   = 1024;
  localparam logic [15:0] IO_BASE = 16'hFF00;

  localparam int K_RAM    = 0;
  localparam int K_IO_IN  = 1;
  localparam int K_IO_OUT = 2;
  localparam int K_OOR    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic [1:0]  fsm_state;

  mem_responder #(.MEM_DEPTH(DEPTH), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
    .err(err), .io_in(io_in), .io_out(io_out), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mem_m [int];
  int          waddr_q[$];
  logic [15:0] rdata_m  = 16'h0000;
  logic [15:0] io_out_m = 16'h0000;
  logic        seen_err;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int kind_of(input logic [15:0] a);
`ifdef MEM_IO_EN
    if (a == IO_BASE) return K_IO_IN;
    if (a == IO_BASE + 16'd1) return K_IO_OUT;
    if (int'(a) >= int'(IO_BASE) && int'(a) < int'(IO_BASE) + 256) return K_OOR;
`endif
    return (int'(a) < DEPTH) ? K_RAM : K_OOR;
  endfunction

  // One complete access, entered and left on a falling edge. Checks the
  // handshake timing, err, rdata and io_out against the model.
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] d);
    int   k;
    logic exp_err;
    k = kind_of(a);
    if (rd && wr)  exp_err = 1'b1;
    else if (wr)   exp_err = !(k == K_RAM || k == K_IO_OUT);
    else           exp_err = (k == K_OOR);
    memread  = rd;
    memwrite = wr;
    addr     = a;
    wdata    = d;
    @(posedge clk);
    @(negedge clk);
    memread  = 1'b0;
    memwrite = 1'b0;
    if (rd && !wr) begin
      check("rd_wait_busy", {15'd0, busy}, 16'd1);
      check("rd_wait_ready", {15'd0, ready}, 16'd0);
      case (k)
        K_RAM:    rdata_m = mem_m[int'(a)];
        K_IO_IN:  rdata_m = io_in;
        K_IO_OUT: rdata_m = io_out_m;
        default:  rdata_m = 16'h0000;
      endcase
      exp_q.push_back(rdata_m);
      @(posedge clk);
      @(negedge clk);
    end else if (wr && !rd) begin
      if (k == K_RAM) begin
        if (!mem_m.exists(int'(a))) waddr_q.push_back(int'(a));
        mem_m[int'(a)] = d;
      end else if (k == K_IO_OUT) begin
        io_out_m = d;
      end
    end
    seen_err = err;
    check("ack_ready", {15'd0, ready}, 16'd1);
    check("ack_err", {15'd0, err}, {15'd0, exp_err});
    if (rd && !wr) check("rdata", rdata, exp_q.pop_front());
    else           check("rdata_held", rdata, rdata_m);
    check("io_out", io_out, io_out_m);
    @(posedge clk);
    @(negedge clk);
    check("idle_ready", {15'd0, ready}, 16'd0);
    check("idle_busy", {15'd0, busy}, 16'd0);
    check("idle_err", {15'd0, err}, 16'd0);
  endtask

  initial begin
    reset    = 1'b1;
    memread  = 1'b0;
    memwrite = 1'b0;
    addr     = 16'h0000;
    wdata    = 16'h0000;
    io_in    = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_ready", {15'd0, ready}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_err", {15'd0, err}, 16'd0);
    check("rst_io_out", io_out, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    // write then read
    do_access(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    check("wr_err", {15'd0, seen_err}, 16'd0);
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000);
    check("rd_beef", rdata, 16'hBEEF);

    // simultaneous read and write: no access, err, rdata unchanged
    do_access(1'b1, 1'b1, 16'h0010, 16'h1111);
    check("both_err", {15'd0, seen_err}, 16'd1);
    check("both_rdata", rdata, 16'hBEEF);
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000);
    check("both_ram_kept", rdata, 16'hBEEF);

    // range boundaries and out-of-range
    do_access(1'b0, 1'b1, 16'h03FF, 16'h7E57);
    do_access(1'b0, 1'b1, 16'h0000, 16'h1357);
    do_access(1'b1, 1'b0, 16'h0400, 16'h0000);
    check("oor_rd_data", rdata, 16'h0000);
    check("oor_rd_err", {15'd0, seen_err}, 16'd1);
    do_access(1'b0, 1'b1, 16'h0400, 16'hDEAD);
    check("oor_wr_err", {15'd0, seen_err}, 16'd1);
    do_access(1'b1, 1'b0, 16'h0000, 16'h0000);
    check("no_alias_0", rdata, 16'h1357);
    do_access(1'b0, 1'b1, 16'h0410, 16'h5555);
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000);
    check("no_alias_10", rdata, 16'hBEEF);
    do_access(1'b1, 1'b0, 16'h03FF, 16'h0000);
    check("top_word", rdata, 16'h7E57);

    // write request raised during RD_WAIT is ignored
    memread = 1'b1;
    addr    = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    memread  = 1'b0;
    memwrite = 1'b1;
    wdata    = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    check("busy_rd_ready", {15'd0, ready}, 16'd1);
    check("busy_rd_data", rdata, 16'hBEEF);
    check("busy_rd_err", {15'd0, err}, 16'd0);
    memwrite = 1'b0;
    @(posedge clk);
    @(negedge clk);
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000);
    check("busy_wr_ignored", rdata, 16'hBEEF);

    // write held through ACK is taken again on the IDLE edge
    memwrite = 1'b1;
    addr     = 16'h0020;
    wdata    = 16'hA0A0;
    @(posedge clk);
    @(negedge clk);
    check("hold_ack1", {15'd0, ready}, 16'd1);
    wdata = 16'hB0B0;
    @(posedge clk);
    @(negedge clk);
    check("hold_idle", {15'd0, busy}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    check("hold_ack2", {15'd0, ready}, 16'd1);
    check("hold_err2", {15'd0, err}, 16'd0);
    memwrite = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mem_m[32] = 16'hB0B0;
    waddr_q.push_back(32);
    do_access(1'b1, 1'b0, 16'h0020, 16'h0000);
    check("hold_second_wr", rdata, 16'hB0B0);

    // reset in RD_WAIT aborts the read
    memread = 1'b1;
    addr    = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    memread = 1'b0;
    reset   = 1'b1;
    #1;
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_ready", {15'd0, ready}, 16'd0);
    check("mid_rst_rdata", rdata, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_no_ready", {15'd0, ready}, 16'd0);
    reset    = 1'b0;
    rdata_m  = 16'h0000;
    io_out_m = 16'h0000;
    @(negedge clk);
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000);
    check("mid_rst_ram_kept", rdata, 16'hBEEF);

    // I/O window
    do_access(1'b0, 1'b1, IO_BASE + 16'd1, 16'h00A5);
`ifdef MEM_IO_EN
    check("io_out_a5", io_out, 16'h00A5);
    io_in = 16'h1234;
    do_access(1'b1, 1'b0, IO_BASE, 16'h0000);
    check("io_in_rd", rdata, 16'h1234);
    do_access(1'b1, 1'b0, IO_BASE + 16'd1, 16'h0000);
    check("io_out_rd", rdata, 16'h00A5);
    do_access(1'b0, 1'b1, IO_BASE, 16'hFFFF);
    check("io_in_wr_err", {15'd0, seen_err}, 16'd1);
`else
    check("noio_wr_err", {15'd0, seen_err}, 16'd1);
    check("noio_io_out", io_out, 16'h0000);
    io_in = 16'h1234;
    do_access(1'b1, 1'b0, IO_BASE, 16'h0000);
    check("noio_rd", rdata, 16'h0000);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      int          op;
      logic [15:0] a;
      op    = $urandom_range(0, 5);
      io_in = 16'($urandom);
      case (op)
        0, 1: begin
          a = 16'($urandom_range(0, DEPTH - 1));
          do_access(1'b0, 1'b1, a, 16'($urandom));
        end
        2, 3: begin
          a = 16'(waddr_q[$urandom_range(0, waddr_q.size() - 1)]);
          do_access(1'b1, 1'b0, a, 16'h0000);
        end
        4: begin
          a = 16'($urandom_range(DEPTH, 16'hFEFF));
          if ($urandom_range(0, 1) == 1) do_access(1'b1, 1'b0, a, 16'h0000);
          else                           do_access(1'b0, 1'b1, a, 16'($urandom));
        end
        default: begin
          a = 16'($urandom);
          do_access(1'b1, 1'b1, a, 16'($urandom));
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
